// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port Memory between the Processor fetch path (read-only)
// and the loader/debug port (read/write). Arbitration is round-robin with a
// burst limit: a requester may hold the Memory for at most BURST_MAX
// consecutive grants while the other side is waiting. An idle cycle ends a
// burst. Read data comes back one cycle after the grant on the shared rdata
// bus, tagged by cpuRvalid / ldrRvalid.
//
// Ports
//   clk, reset     single clock, synchronous active-high reset
//   cpuReq/cpuAddr Processor read request (held until cpuGnt)
//   cpuGnt         Processor access accepted this cycle (combinational)
//   cpuRvalid      rdata carries Processor read data this cycle
//   ldrReq/ldrWe/ldrAddr/ldrWdata   loader request (held until ldrGnt)
//   ldrGnt         loader access accepted this cycle (combinational)
//   ldrRvalid      rdata carries loader read data this cycle
//   rdata          shared read-return bus (pass-through of memDataRead)
//   memAddr/memStrobe/memWe/memWdata  toward Memory
//   memDataRead    from Memory, valid the cycle after the strobe
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpuReq,
    input  logic [ADDR_WIDTH-1:0] cpuAddr,
    output logic                  cpuGnt,
    output logic                  cpuRvalid,
    input  logic                  ldrReq,
    input  logic                  ldrWe,
    input  logic [ADDR_WIDTH-1:0] ldrAddr,
    input  logic [DATA_WIDTH-1:0] ldrWdata,
    output logic                  ldrGnt,
    output logic                  ldrRvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memStrobe,
    output logic                  memWe,
    output logic [DATA_WIDTH-1:0] memWdata,
    input  logic [DATA_WIDTH-1:0] memDataRead
);

    // The burst counter saturates at BURST_MAX, which is at most 15.
    localparam logic [3:0] CNT_MAX = 4'(BURST_MAX);

    // last: 0 = Processor, 1 = loader received the most recent grant.
    logic       last;
    logic       lastNext;
    logic [3:0] cnt;
    logic [3:0] cntNext;

    logic       grantCpu;
    logic       grantLdr;

    logic       cpuVld_p1;
    logic       ldrVld_p1;

    // Grant decision. Under contention the previous owner keeps the Memory
    // only while its burst is not exhausted; otherwise the other side wins.
    always_comb begin
        grantCpu = 1'b0;
        grantLdr = 1'b0;
        if (!reset) begin
            if (cpuReq && ldrReq) begin
                if (cnt < CNT_MAX) begin
                    grantLdr = last;
                    grantCpu = ~last;
                end else begin
                    grantLdr = ~last;
                    grantCpu = last;
                end
            end else begin
                grantCpu = cpuReq;
                grantLdr = ldrReq;
            end
        end
    end

    // Burst bookkeeping: a cycle with no grant closes the burst, so the next
    // contended cycle goes to whichever side did not own the last grant.
    always_comb begin
        lastNext = last;
        cntNext  = cnt;
        if (grantCpu || grantLdr) begin
            if (grantLdr == last) begin
                if (cnt < CNT_MAX) begin
                    cntNext = cnt + 4'd1;
                end
            end else begin
                lastNext = grantLdr;
                cntNext  = 4'd1;
            end
        end else begin
            cntNext = CNT_MAX;
        end
    end

    // Stage p0 -> p1: grant cycle to read-return cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            last      <= 1'b1;
            cnt       <= CNT_MAX;
            cpuVld_p1 <= 1'b0;
            ldrVld_p1 <= 1'b0;
        end else begin
            last      <= lastNext;
            cnt       <= cntNext;
            cpuVld_p1 <= grantCpu;
            ldrVld_p1 <= grantLdr & ~ldrWe;
        end
    end

    assign cpuGnt    = grantCpu;
    assign ldrGnt    = grantLdr;

    // A reset arriving in the return cycle cancels the pending read pulse.
    assign cpuRvalid = cpuVld_p1 & ~reset;
    assign ldrRvalid = ldrVld_p1 & ~reset;
    assign rdata     = memDataRead;

    assign memStrobe = grantCpu | grantLdr;
    assign memAddr   = grantLdr ? ldrAddr : cpuAddr;
    assign memWe     = grantLdr & ldrWe;
    assign memWdata  = ldrWdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two arbiters share one stimulus stream: instance 0 with BURST_MAX=4 and
// instance 1 with BURST_MAX=1. Each has its own Memory. A behavioural model
// of the arbitration rules predicts grants, Memory controls and read returns
// every cycle; directed sequences pin the model with literal expectations,
// then a randomized phase exercises contention, writes and resets.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpuReq;
    logic [7:0] cpuAddr;
    logic       ldrReq;
    logic       ldrWe;
    logic [7:0] ldrAddr;
    logic [7:0] ldrWdata;

    logic       cpuGnt    [2];
    logic       cpuRvalid [2];
    logic       ldrGnt    [2];
    logic       ldrRvalid [2];
    logic [7:0] rdata     [2];
    logic [7:0] memAddr   [2];
    logic       memStrobe [2];
    logic       memWe     [2];
    logic [7:0] memWdata  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] initVal(input int a);
        return 8'(a * 7 + 3);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gInst
        logic [7:0] mem [256];
        logic [7:0] md;

        // Behavioural single-port Memory, reloaded with its pattern in reset.
        always @(posedge clk) begin
            if (reset) begin
                for (int a = 0; a < 256; a++) mem[a] <= initVal(a);
            end else if (memStrobe[g]) begin
                if (memWe[g]) mem[memAddr[g]] <= memWdata[g];
                else          md <= mem[memAddr[g]];
            end
        end

        mem_port_arbiter #(
            .ADDR_WIDTH(8),
            .DATA_WIDTH(8),
            .BURST_MAX (g == 0 ? 4 : 1)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .cpuReq     (cpuReq),
            .cpuAddr    (cpuAddr),
            .cpuGnt     (cpuGnt[g]),
            .cpuRvalid  (cpuRvalid[g]),
            .ldrReq     (ldrReq),
            .ldrWe      (ldrWe),
            .ldrAddr    (ldrAddr),
            .ldrWdata   (ldrWdata),
            .ldrGnt     (ldrGnt[g]),
            .ldrRvalid  (ldrRvalid[g]),
            .rdata      (rdata[g]),
            .memAddr    (memAddr[g]),
            .memStrobe  (memStrobe[g]),
            .memWe      (memWe[g]),
            .memWdata   (memWdata[g]),
            .memDataRead(md)
        );
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: owner of the last grant, length of the current
    // burst, one pending read return, and a shadow copy of each Memory.
    // ------------------------------------------------------------------
    int         mLast [2];
    int         mCnt  [2];
    logic       pendC [2] = '{1'b0, 1'b0};
    logic       pendL [2] = '{1'b0, 1'b0};
    logic [7:0] pendD [2];
    logic [7:0] sm    [2][256];

    always @(negedge clk) begin
        int         bm;
        int         winner;   // -1 none, 0 cpu, 1 ldr
        logic       eC;
        logic       eL;
        logic [7:0] ea;
        for (int g = 0; g < 2; g++) begin
            bm     = (g == 0) ? 4 : 1;
            winner = -1;
            if (!reset) begin
                if (cpuReq && ldrReq) winner = (mCnt[g] < bm) ? mLast[g] : 1 - mLast[g];
                else if (cpuReq)      winner = 0;
                else if (ldrReq)      winner = 1;
            end
            eC = (winner == 0);
            eL = (winner == 1);
            ea = eL ? ldrAddr : cpuAddr;

            chk1($sformatf("i%0d cpuGnt", g), cpuGnt[g], eC);
            chk1($sformatf("i%0d ldrGnt", g), ldrGnt[g], eL);
            chk1($sformatf("i%0d memStrobe", g), memStrobe[g], eC | eL);
            chk1($sformatf("i%0d memWe", g), memWe[g], eL & ldrWe);
            chk8($sformatf("i%0d memAddr", g), memAddr[g], ea);
            chk8($sformatf("i%0d memWdata", g), memWdata[g], ldrWdata);
            chk1($sformatf("i%0d cpuRvalid", g), cpuRvalid[g], pendC[g] & ~reset);
            chk1($sformatf("i%0d ldrRvalid", g), ldrRvalid[g], pendL[g] & ~reset);
            if ((pendC[g] || pendL[g]) && !reset)
                chk8($sformatf("i%0d rdata", g), rdata[g], pendD[g]);

            if (reset) begin
                mLast[g] = 1;
                mCnt[g]  = bm;
                pendC[g] = 1'b0;
                pendL[g] = 1'b0;
                for (int a = 0; a < 256; a++) sm[g][a] = initVal(a);
            end else begin
                pendC[g] = eC;
                pendL[g] = eL & ~ldrWe;
                pendD[g] = sm[g][ea];
                if (eL && ldrWe) sm[g][ldrAddr] = ldrWdata;
                if (winner < 0) begin
                    mCnt[g] = bm;
                end else if (winner == mLast[g]) begin
                    mCnt[g] = (mCnt[g] + 1 > bm) ? bm : mCnt[g] + 1;
                end else begin
                    mLast[g] = winner;
                    mCnt[g]  = 1;
                end
            end
        end
    end

    task automatic nextCyc();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] t1Exp [4] = '{8'h03, 8'h0A, 8'h11, 8'h18};

    initial begin
        reset = 1'b1; cpuReq = 1'b0; cpuAddr = 8'h00;
        ldrReq = 1'b0; ldrWe = 1'b0; ldrAddr = 8'h00; ldrWdata = 8'h00;
        nextCyc();
        cpuReq = 1'b1; ldrReq = 1'b1;
        #3;
        chk1("reset cpuGnt", cpuGnt[0], 1'b0);
        chk1("reset ldrGnt", ldrGnt[0], 1'b0);
        chk1("reset memStrobe", memStrobe[0], 1'b0);
        chk1("reset cpuRvalid", cpuRvalid[0], 1'b0);
        nextCyc();

        // Processor streaming reads with no loader traffic.
        reset = 1'b0; ldrReq = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cpuReq  = (i < 4);
            cpuAddr = 8'(i);
            #3;
            if (i < 4) chk1("t1 cpuGnt", cpuGnt[0], 1'b1);
            if (i > 0) begin
                chk1("t1 cpuRvalid", cpuRvalid[0], 1'b1);
                chk8("t1 rdata", rdata[0], t1Exp[i-1]);
            end
            nextCyc();
        end

        // Continuous contention from reset: bursts of 4 vs strict alternation.
        reset = 1'b1; cpuReq = 1'b0; ldrReq = 1'b0;
        nextCyc();
        reset = 1'b0; cpuReq = 1'b1; ldrReq = 1'b1;
        cpuAddr = 8'h30; ldrAddr = 8'h20; ldrWe = 1'b0;
        for (int k = 0; k < 12; k++) begin
            #3;
            chk1("t2 ldrGnt", ldrGnt[0], 1'((k / 4) % 2));
            chk1("t2 cpuGnt", cpuGnt[0], 1'(1 - (k / 4) % 2));
            chk1("t2 memStrobe", memStrobe[0], 1'b1);
            chk1("t6 ldrGnt", ldrGnt[1], 1'(k % 2));
            if (k > 0) begin
                chk1("t6 cpuRvalid", cpuRvalid[1], 1'((k - 1) % 2 == 0));
                chk1("t6 ldrRvalid", ldrRvalid[1], 1'((k - 1) % 2));
            end
            nextCyc();
        end

        // Loader write then Processor read-back of the same location.
        cpuReq = 1'b0; ldrReq = 1'b1; ldrWe = 1'b1; ldrAddr = 8'h10; ldrWdata = 8'hA5;
        #3;
        chk1("t3 ldrGnt", ldrGnt[0], 1'b1);
        chk1("t3 memWe", memWe[0], 1'b1);
        nextCyc();
        ldrReq = 1'b0; ldrWe = 1'b0; cpuReq = 1'b1; cpuAddr = 8'h10;
        #3;
        chk1("t3 ldrRvalid", ldrRvalid[0], 1'b0);
        chk1("t3 memWe off", memWe[0], 1'b0);
        nextCyc();
        cpuReq = 1'b0;
        #3;
        chk1("t3 cpuRvalid", cpuRvalid[0], 1'b1);
        chk8("t3 rdata", rdata[0], 8'hA5);
        nextCyc();

        // Idle cycle ends the Processor burst.
        cpuReq = 1'b1; cpuAddr = 8'h01;
        nextCyc();
        cpuAddr = 8'h02;
        nextCyc();
        cpuReq = 1'b0;
        nextCyc();
        cpuReq = 1'b1; ldrReq = 1'b1; ldrWe = 1'b0; ldrAddr = 8'h04;
        #3;
        chk1("t4 ldrGnt", ldrGnt[0], 1'b1);
        chk1("t4 cpuGnt", cpuGnt[0], 1'b0);
        nextCyc();

        // Reset in the return cycle of a loader read.
        cpuReq = 1'b0; ldrReq = 1'b1; ldrWe = 1'b0; ldrAddr = 8'h05;
        #3;
        chk1("t5 ldrGnt", ldrGnt[0], 1'b1);
        nextCyc();
        reset = 1'b1; cpuReq = 1'b1; ldrReq = 1'b1;
        #3;
        chk1("t5 ldrRvalid", ldrRvalid[0], 1'b0);
        chk1("t5 ldrGnt", ldrGnt[0], 1'b0);
        chk1("t5 cpuGnt", cpuGnt[0], 1'b0);
        chk1("t5 memStrobe", memStrobe[0], 1'b0);
        nextCyc();
        reset = 1'b0;
        #3;
        chk1("t5 cpu first", cpuGnt[0], 1'b1);
        chk1("t5 ldr waits", ldrGnt[0], 1'b0);
        nextCyc();

        // Randomized traffic over a small address window.
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(63) == 0);
            cpuReq   = ($urandom_range(99) < 70);
            ldrReq   = ($urandom_range(99) < 70);
            ldrWe    = ($urandom_range(1) == 1);
            cpuAddr  = 8'($urandom_range(15));
            ldrAddr  = 8'($urandom_range(15));
            ldrWdata = 8'($urandom);
            nextCyc();
        end

        reset = 1'b0; cpuReq = 1'b0; ldrReq = 1'b0;
        nextCyc();
        nextCyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
